// File: rtl/if_stage.sv
// IF stage: owns the PC, fetches from a 1-cycle synchronous SRAM and presents one word per cycle to ID.
// Latency: address issued in t, word presented in t+1; on ID stall the SRAM idles and the word is held in a 1-entry buffer.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allow_in,
   input  logic        br_taken_cancel,
   input  logic [31:0] br_target,
   input  logic [31:0] inst_sram_rdata,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   output logic        to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst
);

   localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

   logic [31:0] fs_pc_q, fs_pc_d;
   logic        fs_valid_q, fs_valid_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        buf_valid_q, buf_valid_d;

   logic        fs_allow_in;
   logic        issue;
   logic        capture;
   logic [31:0] nextpc;

   assign fs_allow_in = !fs_valid_q || ds_allow_in;
   assign nextpc      = br_taken_cancel ? br_target : fs_pc_q + 32'd4;
   // A redirect always fetches, even while ID is stalled; reset gates the request combinationally.
   assign issue       = reset && (fs_allow_in || br_taken_cancel);
   assign capture     = fs_valid_q && !ds_allow_in && !buf_valid_q && !br_taken_cancel;

   always_comb begin
      fs_pc_d     = fs_pc_q;
      fs_valid_d  = fs_valid_q;
      buf_inst_d  = buf_inst_q;
      buf_valid_d = buf_valid_q;
      if (issue) begin
         fs_pc_d     = nextpc;
         fs_valid_d  = 1'b1;
         buf_valid_d = 1'b0;
      end else if (fs_valid_q && ds_allow_in) begin
         fs_valid_d = 1'b0;
      end
      // SRAM data is only valid the cycle after the read, so latch it on the first stall cycle.
      if (capture) begin
         buf_inst_d  = inst_sram_rdata;
         buf_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fs_pc_q     <= PC_INIT;
         fs_valid_q  <= 1'b0;
         buf_inst_q  <= 32'd0;
         buf_valid_q <= 1'b0;
      end else begin
         fs_pc_q     <= fs_pc_d;
         fs_valid_q  <= fs_valid_d;
         buf_inst_q  <= buf_inst_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   assign inst_sram_en    = issue;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;

   assign to_ds_valid = fs_valid_q && !br_taken_cancel;
   assign fs_pc       = fs_pc_q;
   assign fs_inst     = buf_valid_q ? buf_inst_q : inst_sram_rdata;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: the model is the ordered PC stream ID must receive; SRAM returns its address as data.
module tb_if_stage;
   localparam logic [31:0] RESET_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allow_in;
   logic        br_taken_cancel;
   logic [31:0] br_target;
   logic [31:0] inst_sram_rdata = 32'd0;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;

   int          checks = 0;
   int          errors = 0;
   int          xfers  = 0;
   int          idle   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_next;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_pc, prev_inst;

   if_stage dut (
      .clk(clk), .reset(reset), .ds_allow_in(ds_allow_in),
      .br_taken_cancel(br_taken_cancel), .br_target(br_target),
      .inst_sram_rdata(inst_sram_rdata), .inst_sram_en(inst_sram_en),
      .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata), .to_ds_valid(to_ds_valid),
      .fs_pc(fs_pc), .fs_inst(fs_inst)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM: data = address when read, garbage otherwise.
   always @(posedge clk) inst_sram_rdata <= inst_sram_en ? inst_sram_addr : $urandom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic allow, input logic cancel, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      ds_allow_in     = allow;
      br_taken_cancel = cancel;
      br_target       = cancel ? tgt : $urandom;
      if (cancel) begin
         exp_q.delete();
         exp_q.push_back(tgt);
         model_next = tgt + 32'd4;
      end else if (exp_q.size() == 0) begin
         exp_q.push_back(model_next);
         model_next = model_next + 32'd4;
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset           = 1'b1;
      ds_allow_in     = 1'b1;
      br_taken_cancel = 1'b0;
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      model_next = RESET_PC + 32'd4;
      #1;
      check("first_en", 32'(inst_sram_en), 32'd1);
      check("first_addr", inst_sram_addr, RESET_PC);
   endtask

   // Monitor: pops the expected stream on every transfer and checks stall/redirect rules.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_to_ds_valid", 32'(to_ds_valid), 32'd0);
         check("rst_sram_en", 32'(inst_sram_en), 32'd0);
         prev_stall = 1'b0;
         idle = 0;
      end else begin
         if (prev_stall) begin
            check("stall_pc", fs_pc, prev_pc);
            check("stall_inst", fs_inst, prev_inst);
         end
         if (br_taken_cancel) begin
            check("cancel_valid", 32'(to_ds_valid), 32'd0);
            check("cancel_en", 32'(inst_sram_en), 32'd1);
            check("cancel_addr", inst_sram_addr, br_target);
         end else if (to_ds_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer: got pc %h expected none", fs_pc);
            end else begin
               check("pc", fs_pc, exp_q[0]);
               check("inst", fs_inst, exp_q[0]);
               if (ds_allow_in) begin
                  check("issue_en", 32'(inst_sram_en), 32'd1);
                  check("issue_addr", inst_sram_addr, exp_q[0] + 32'd4);
                  void'(exp_q.pop_front());
                  xfers++;
               end else begin
                  check("stall_en", 32'(inst_sram_en), 32'd0);
               end
            end
         end
         prev_stall = to_ds_valid && !ds_allow_in;
         prev_pc    = fs_pc;
         prev_inst  = fs_inst;
         if (to_ds_valid && ds_allow_in) idle = 0;
         else idle++;
         if (idle > 60) begin
            checks++;
            errors++;
            $display("FAIL liveness: got %0d idle cycles expected at most 60", idle);
            idle = 0;
         end
      end
   end

   initial begin
      reset = 1'b0; ds_allow_in = 1'b0; br_taken_cancel = 1'b0; br_target = 32'd0;
      #12;
      check("rst_pc", fs_pc, RESET_PC - 32'd4);
      check("rst_en", 32'(inst_sram_en), 32'd0);
      check("we_zero", 32'(inst_sram_we), 32'd0);
      check("wdata_zero", inst_sram_wdata, 32'd0);
      release_reset();
      drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("first_pc", fs_pc, RESET_PC);
      check("first_valid", 32'(to_ds_valid), 32'd1);
      drive(1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      @(negedge clk);
      check("held_inst", fs_inst, 32'h1c000008);
      check("held_en", 32'(inst_sram_en), 32'd0);
      drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("resume_addr", inst_sram_addr, 32'h1c00000c);
      drive(1'b1, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 32'h1c000100);
      @(negedge clk);
      check("redir_from_pc", fs_pc, 32'h1c000010);
      drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("redir_pc", fs_pc, 32'h1c000100);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b1, 32'h1c000100);
      drive(1'b0, 1'b0, 32'd0);
      @(negedge clk);
      check("redir_stall_pc", fs_pc, 32'h1c000100);
      check("redir_stall_inst", fs_inst, 32'h1c000100);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b1, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 32'hfffffffc);
      drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("wrap_pc", fs_pc, 32'hfffffffc);
      check("wrap_addr", inst_sram_addr, 32'h00000000);
      drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("wrapped_pc", fs_pc, 32'h00000000);
      drive(1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("async_valid", 32'(to_ds_valid), 32'd0);
      check("async_en", 32'(inst_sram_en), 32'd0);
      check("async_pc", fs_pc, RESET_PC - 32'd4);
      @(posedge clk);
      @(posedge clk);
      release_reset();
      for (int i = 0; i < 3000; i++) begin
         logic        c;
         logic        a;
         logic [31:0] t;
         c = ($urandom_range(0, 99) < 8);
         a = i[8] ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 85);
         t = RESET_PC + (32'($urandom_range(0, 1023)) << 2);
         drive(a, c, t);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd0);
      @(negedge clk);
      check("xfer_count_ok", 32'(xfers > 1000), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the LA32R five-stage pipeline, the producer side of the IF→ID handshake. It owns the PC, issues requests to a synchronous instruction SRAM (1-cycle read latency), and holds the fetched word when ID stalls. It presents `pc`/`inst`/`to_ds_valid` to ID and accepts redirection through `br_taken_cancel`/`br_target`. A one-entry instruction buffer guarantees that no fetched word is lost or duplicated under back-pressure.

## Interface
- `RESET_PC`, 32'h1c000000, address of the first instruction fetched after reset.
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `ds_allow_in`  input  1  ID can accept an instruction this cycle.
- `br_taken_cancel`  input  1  ID resolved a taken branch/jump this cycle.
- `br_target`  input  32  redirect address, valid when `br_taken_cancel`=1.
- `inst_sram_rdata`  input  32  SRAM read data for the address issued the previous cycle.
- `inst_sram_en`  output  1  SRAM read request.
- `inst_sram_we`  output  4  constant 4'b0.
- `inst_sram_addr`  output  32  SRAM read address (`nextpc`).
- `inst_sram_wdata`  output  32  constant 32'b0.
- `to_ds_valid`  output  1  `pc`/`inst` hold a valid instruction for ID.
- `fs_pc`  output  32  PC of the instruction in IF.
- `fs_inst`  output  32  instruction word in IF.

## Operation
- State: `fs_pc` (32), `fs_valid` (1), `buf_inst` (32), `buf_valid` (1).
- `fs_ready_go` = 1. `fs_allow_in` = !`fs_valid` | `ds_allow_in`.
- `nextpc` = `br_taken_cancel` ? `br_target` : `fs_pc` + 4 (32-bit, wraps modulo 2^32).
- Issue (pre-IF): `inst_sram_en` = `reset` & (`fs_allow_in` | `br_taken_cancel`). `inst_sram_addr` = `nextpc`.
- On an issue edge: `fs_pc` <= `nextpc`, `fs_valid` <= 1, `buf_valid` <= 0.
- No issue and `fs_valid` & `ds_allow_in` (instruction consumed, nothing new): `fs_valid` <= 0. This cannot occur in normal operation because consumption implies `fs_allow_in`. It is listed for completeness.
- `fs_inst` = `buf_valid` ? `buf_inst` : `inst_sram_rdata`.
- Capture: when `fs_valid` & !`ds_allow_in` & !`buf_valid` & !`br_taken_cancel`, then `buf_inst` <= `inst_sram_rdata` and `buf_valid` <= 1. The buffer holds until the instruction leaves IF or is cancelled.
- `to_ds_valid` = `fs_valid` & !`br_taken_cancel`. The sequential fall-through word in IF at redirect time is discarded and never presented to ID again.
- Cancel has priority over stall. A redirect always issues `br_target` that cycle, even if `ds_allow_in`=0. The fetched target then waits in IF, buffered if needed.
- `inst_sram_we`/`inst_sram_wdata` are tied to 0. IF never writes.

## Timing
- Reset (`reset`=0, asynchronous): `fs_pc` = `RESET_PC` − 4, `fs_valid` = 0, `buf_valid` = 0, `buf_inst` = 0.
- Reset outputs: `inst_sram_en` = 0, `to_ds_valid` = 0, `fs_pc` = `RESET_PC` − 4, `fs_inst` = `inst_sram_rdata` (don't-care).
- First cycle after release: `inst_sram_en`=1 and `inst_sram_addr`=`RESET_PC`. Next cycle: `to_ds_valid`=1 and `fs_pc`=`RESET_PC`.
- Fetch latency: address issued in cycle t, word presented on `fs_inst` in cycle t+1. Throughput is 1 instruction/cycle without stalls.
- Handshake: transfer to ID occurs on an edge where `to_ds_valid` & `ds_allow_in`. `fs_pc`/`fs_inst` stay stable while `to_ds_valid`=1 and `ds_allow_in`=0.
- Redirect: `br_taken_cancel` in cycle t sets `inst_sram_addr`=`br_target` in t. In t+1: `fs_pc`=`br_target`, `to_ds_valid`=1, `fs_inst`=word at target.
- Stall longer than 1 cycle: the SRAM is not re-enabled, and `fs_inst` is served from `buf_inst` from the 2nd stall cycle onward.
- Reset asserted mid-stall or mid-redirect: all state is cleared immediately and the buffered word is dropped.

## Test plan
- Reset release, `ds_allow_in`=1, SRAM model returns the address as data → `inst_sram_addr` is 0x1c000000, 0x1c000004, …; `fs_pc` lags by 1 cycle; `fs_inst`==`fs_pc` each cycle.
- Hold `ds_allow_in`=0 for 3 cycles while `fs_pc`=0x1c000008; the SRAM model drives garbage after the first cycle → `fs_inst` stays 0x1c000008 and `inst_sram_en`=0 during the stall. On release, the next issue is 0x1c00000c with no duplicate or skip.
- `br_taken_cancel`=1 with `br_target`=0x1c000100 while `fs_pc`=0x1c000010 → `to_ds_valid`=0 that cycle. Next cycle `fs_pc`=0x1c000100, and 0x1c000010 is never transferred.
- Redirect asserted while `ds_allow_in`=0 and `buf_valid`=1 → buffer is discarded, 0x1c000100 is fetched, held stable until `ds_allow_in`=1, then transferred once.
- `fs_pc`=0xfffffffc with a sequential fetch → `nextpc` wraps to 0x00000000.
- Drop `reset` to 0 asynchronously (not on a clock edge) during a stall → `to_ds_valid` and `inst_sram_en` fall to 0 immediately. After release, the first request is 0x1c000000.
